// File: rtl/decode_stage_buf.sv
// decode_stage_buf: registered RV32I decode stage sitting between IF/ID and EX.
// Decodes in_instr combinationally and captures the decoded bundle on accept
// (in_valid & in_ready) into a FIFO skid buffer of SKID_DEPTH (1 or 2) entries.
// Output presents entry 0. Order is strictly FIFO. flush empties the buffer.
//
// Optional feature macro: ILLEGAL_INSTR_EN
//   defined   -> unknown opcodes and R-type with bad funct7 raise out_illegal,
//                and reg_w/mem_w/branch/jump are forced low for that entry.
//   undefined -> out_illegal tied 0; unknown opcodes decode to all-zero controls.
//
// Ports:
//   clk, rst_n (async active-low), flush
//   in_valid/in_ready/in_instr/in_pc     : fetch side handshake
//   out_valid/out_ready                  : EX side handshake
//   out_pc, out_imm                      : PC and sign-extended immediate
//   out_rs1/rs2/rd/funct3/funct7b5       : raw instruction fields
//   out_reg_w .. out_illegal             : main-decoder control bundle
module decode_stage_buf #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_reg_w,
  output logic            out_mem_w,
  output logic            out_alu_src,
  output logic            out_alu_a_pc,
  output logic [1:0]      out_result_src,
  output logic [2:0]      out_imm_src,
  output logic [1:0]      out_alu_op,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_jalr,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_w;
    logic            mem_w;
    logic            alu_src;
    logic            alu_a_pc;
    logic [1:0]      result_src;
    logic [2:0]      imm_src;
    logic [1:0]      alu_op;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t  state_q, state_d;
  bundle_t ent0_q, ent0_d, ent1_q, ent1_d;
  bundle_t dec;
  logic    in_ready_q;
  logic    accept, pop, unknown;
  logic signed [31:0] imm32;

  // Combinational main decoder
  always_comb begin
    dec          = '0;
    unknown      = 1'b0;
    imm32        = '0;
    dec.pc       = in_pc;
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.rd       = in_instr[11:7];
    dec.funct3   = in_instr[14:12];
    dec.funct7b5 = in_instr[30];
    case (in_instr[6:0])
      7'b0000011: begin dec.reg_w = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01; end
      7'b0100011: begin dec.imm_src = 3'b001; dec.alu_src = 1'b1; dec.mem_w = 1'b1; end
      7'b0110011: begin dec.reg_w = 1'b1; dec.alu_op = 2'b10; end
      7'b1100011: begin dec.imm_src = 3'b010; dec.branch = 1'b1; dec.alu_op = 2'b01; end
      7'b0010011: begin dec.reg_w = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b10; end
      7'b1101111: begin
        dec.reg_w = 1'b1; dec.imm_src = 3'b011; dec.alu_src = 1'b1;
        dec.alu_a_pc = 1'b1; dec.result_src = 2'b10; dec.jump = 1'b1;
      end
      7'b1100111: begin
        dec.reg_w = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b10;
        dec.jump = 1'b1; dec.jalr = 1'b1;
      end
      7'b0110111: begin
        dec.reg_w = 1'b1; dec.imm_src = 3'b100; dec.alu_src = 1'b1; dec.result_src = 2'b11;
      end
      7'b0010111: begin
        dec.reg_w = 1'b1; dec.imm_src = 3'b100; dec.alu_src = 1'b1; dec.alu_a_pc = 1'b1;
      end
      default: unknown = 1'b1;
    endcase
`ifdef ILLEGAL_INSTR_EN
    // funct7 legal only as 0000000 or 0100000 (bit 30 is the sole free bit)
    dec.illegal = unknown ||
                  ((in_instr[6:0] == 7'b0110011) && ({in_instr[31], in_instr[29:25]} != 6'd0));
    if (dec.illegal) begin
      dec.reg_w  = 1'b0;
      dec.mem_w  = 1'b0;
      dec.branch = 1'b0;
      dec.jump   = 1'b0;
    end
`else
    dec.illegal = 1'b0;
`endif
    case (dec.imm_src)
      3'b000:  imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010:  imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      3'b011:  imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      3'b100:  imm32 = {in_instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    // signed size cast sign-extends the 32-bit immediate to XLEN
    dec.imm = XLEN'(imm32);
  end

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  generate
    if (SKID_DEPTH == 1) begin : g_pipe
      assign in_ready = ~out_valid | out_ready;
    end else begin : g_skid
      assign in_ready = in_ready_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          ent0_d  = dec;
        end
        ONE: begin
          if (accept && pop) begin
            ent0_d = dec;
          end else if (accept) begin
            state_d = TWO;
            ent1_d  = dec;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d = ONE;
          ent0_d  = ent1_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ent0_q     <= '0;
      ent1_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  assign out_pc         = ent0_q.pc;
  assign out_imm        = ent0_q.imm;
  assign out_rs1        = ent0_q.rs1;
  assign out_rs2        = ent0_q.rs2;
  assign out_rd         = ent0_q.rd;
  assign out_funct3     = ent0_q.funct3;
  assign out_funct7b5   = ent0_q.funct7b5;
  assign out_reg_w      = ent0_q.reg_w;
  assign out_mem_w      = ent0_q.mem_w;
  assign out_alu_src    = ent0_q.alu_src;
  assign out_alu_a_pc   = ent0_q.alu_a_pc;
  assign out_result_src = ent0_q.result_src;
  assign out_imm_src    = ent0_q.imm_src;
  assign out_alu_op     = ent0_q.alu_op;
  assign out_branch     = ent0_q.branch;
  assign out_jump       = ent0_q.jump;
  assign out_jalr       = ent0_q.jalr;
  assign out_illegal    = ent0_q.illegal;

endmodule

// File: tb/tb_decode_stage_buf.sv
// Self-checking bench for decode_stage_buf: directed decode vectors streamed
// at full throughput, then hand-written stall, flush and async-reset sequences.
module tb_decode_stage_buf;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3, out_imm_src;
  logic [1:0]  out_result_src, out_alu_op;
  logic        out_funct7b5, out_reg_w, out_mem_w, out_alu_src, out_alu_a_pc;
  logic        out_branch, out_jump, out_jalr, out_illegal;

  int checks = 0;
  int errors = 0;

  decode_stage_buf #(.XLEN(32), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_reg_w(out_reg_w), .out_mem_w(out_mem_w),
    .out_alu_src(out_alu_src), .out_alu_a_pc(out_alu_a_pc), .out_result_src(out_result_src),
    .out_imm_src(out_imm_src), .out_alu_op(out_alu_op), .out_branch(out_branch),
    .out_jump(out_jump), .out_jalr(out_jalr), .out_illegal(out_illegal)
  );

  // {reg_w, imm_src, alu_src, alu_a_pc, mem_w, result_src, branch, jump, jalr, alu_op, illegal}
  logic [14:0] act_ctrl;
  assign act_ctrl = {out_reg_w, out_imm_src, out_alu_src, out_alu_a_pc, out_mem_w,
                     out_result_src, out_branch, out_jump, out_jalr, out_alu_op, out_illegal};

`ifdef ILLEGAL_INSTR_EN
  localparam logic [14:0] CTRL_BADOP = 15'b0_000_0_0_0_00_0_0_0_00_1;
  localparam logic [14:0] CTRL_BADF7 = 15'b0_000_0_0_0_00_0_0_0_10_1;
`else
  localparam logic [14:0] CTRL_BADOP = 15'b0_000_0_0_0_00_0_0_0_00_0;
  localparam logic [14:0] CTRL_BADF7 = 15'b1_000_0_0_0_00_0_0_0_10_0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [14:0] ctrl;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    logic [31:0] ins;
    vecs[0]  = '{32'h00500093, 15'b1_000_1_0_0_00_0_0_0_10_0, 32'h00000005}; // addi x1,x0,5
    vecs[1]  = '{32'hFE000EE3, 15'b0_010_0_0_0_00_1_0_0_01_0, 32'hFFFFFFFC}; // beq x0,x0,-4
    vecs[2]  = '{32'h0080A103, 15'b1_000_1_0_0_01_0_0_0_00_0, 32'h00000008}; // lw x2,8(x1)
    vecs[3]  = '{32'hFE20AE23, 15'b0_001_1_0_1_00_0_0_0_00_0, 32'hFFFFFFFC}; // sw x2,-4(x1)
    vecs[4]  = '{32'h002081B3, 15'b1_000_0_0_0_00_0_0_0_10_0, 32'h00000002}; // add x3,x1,x2
    vecs[5]  = '{32'h402081B3, 15'b1_000_0_0_0_00_0_0_0_10_0, 32'h00000402}; // sub x3,x1,x2
    vecs[6]  = '{32'h010000EF, 15'b1_011_1_1_0_10_0_1_0_00_0, 32'h00000010}; // jal x1,16
    vecs[7]  = '{32'h00008067, 15'b1_000_1_0_0_10_0_1_1_00_0, 32'h00000000}; // jalr x0,0(x1)
    vecs[8]  = '{32'h123452B7, 15'b1_100_1_0_0_11_0_0_0_00_0, 32'h12345000}; // lui x5
    vecs[9]  = '{32'hFFFFF317, 15'b1_100_1_1_0_00_0_0_0_00_0, 32'hFFFFF000}; // auipc x6
    vecs[10] = '{32'h0000007F, CTRL_BADOP,                    32'h00000000}; // unknown opcode
    vecs[11] = '{32'h202081B3, CTRL_BADF7,                    32'h00000202}; // R-type bad funct7

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ctrl", act_ctrl, 15'd0);
    check("rst_imm", out_imm, 32'd0);
    rst_n = 1'b1;

    // Full-throughput stream: vector i is presented the cycle after its accept
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        ins = vecs[i-1].instr;
        check($sformatf("v%0d_valid", i-1), out_valid, 1'b1);
        check($sformatf("v%0d_ctrl", i-1), act_ctrl, vecs[i-1].ctrl);
        check($sformatf("v%0d_imm", i-1), out_imm, vecs[i-1].imm);
        check($sformatf("v%0d_pc", i-1), out_pc, 32'h1000 + 32'(4*(i-1)));
        check($sformatf("v%0d_fields", i-1),
              {out_rs1, out_rs2, out_rd, out_funct3, out_funct7b5},
              {ins[19:15], ins[24:20], ins[11:7], ins[14:12], ins[30]});
        check($sformatf("v%0d_in_ready", i-1), in_ready, 1'b1);
      end
      drive(1'b1, vecs[i].instr, 32'h1000 + 32'(4*i));
    end
    @(negedge clk);
    check("v11_valid", out_valid, 1'b1);
    check("v11_ctrl", act_ctrl, vecs[11].ctrl);
    check("v11_imm", out_imm, vecs[11].imm);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("drain_valid", out_valid, 1'b0);

    // Stall: three back-to-back with out_ready low
    out_ready = 1'b0;
    drive(1'b1, vecs[0].instr, 32'h2000);
    @(negedge clk);
    check("stall_rdy_after1", in_ready, 1'b1);
    drive(1'b1, vecs[1].instr, 32'h2004);
    @(negedge clk);
    check("stall_rdy_after2", in_ready, 1'b0);
    check("stall_head_pc", out_pc, 32'h2000);
    drive(1'b1, vecs[2].instr, 32'h2008);
    @(negedge clk);
    check("stall_rdy_held", in_ready, 1'b0);
    check("stall_hold_pc", out_pc, 32'h2000);
    check("stall_hold_imm", out_imm, 32'h5);
    check("stall_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_pc_B", out_pc, 32'h2004);
    check("rel_imm_B", out_imm, 32'hFFFFFFFC);
    check("rel_rdy", in_ready, 1'b1);
    @(negedge clk);
    check("rel_pc_C", out_pc, 32'h2008);
    check("rel_valid_C", out_valid, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rel_empty", out_valid, 1'b0);

    // Flush with two entries buffered and in_valid high
    out_ready = 1'b0;
    drive(1'b1, vecs[2].instr, 32'h3000);
    @(negedge clk);
    drive(1'b1, vecs[3].instr, 32'h3004);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, vecs[4].instr, 32'h3008);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush2_valid", out_valid, 1'b0);
    check("flush2_rdy", in_ready, 1'b1);

    // Flush in ONE state with a same-cycle accept that must be dropped
    drive(1'b1, vecs[5].instr, 32'h3010);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, vecs[6].instr, 32'h3014);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush1_valid", out_valid, 1'b0);
    check("flush1_rdy", in_ready, 1'b1);
    @(negedge clk);
    check("flush1_no_ghost", out_valid, 1'b0);
    out_ready = 1'b1;
    drive(1'b1, vecs[8].instr, 32'h3020);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check("post_flush_pc", out_pc, 32'h3020);
    check("post_flush_imm", out_imm, 32'h12345000);

    // Async reset with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, vecs[0].instr, 32'h4000);
    @(negedge clk);
    drive(1'b1, vecs[9].instr, 32'h4004);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check("pre_rst_rdy", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_rdy", in_ready, 1'b1);
    check("arst_ctrl", act_ctrl, 15'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_imm", out_imm, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("arst_after_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_buf.md
Name: decode_stage_buf

Overview:
Registered RV32I instruction-decode stage between the IF/ID boundary and EX. It generalises the combinational main decoder:
- full opcode set (LW, SW, branch, I-type ALU, R-type, JAL, JALR, LUI, AUIPC)
- width-parametrised immediate generation
- valid/ready handshakes, flush, and a 2-entry skid buffer, so in_ready is registered and stalls never drop an instruction.

Parameters:
XLEN, 32, data/PC width; immediates sign-extended to XLEN.
SKID_DEPTH, 2, buffer entries (legal values 1 or 2; 1 = plain pipeline register, in_ready combinational from out_ready).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  discard all buffered entries this cycle.
in_valid  in  1  fetch has an instruction.
in_ready  out  1  stage can accept.
in_instr  in  32  instruction word.
in_pc  in  XLEN  instruction PC.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  EX accepts bundle.
out_pc  out  XLEN  PC of bundle.
out_imm  out  XLEN  sign-extended immediate per imm_src.
out_rs1, out_rs2, out_rd  out  5 each  register fields.
out_funct3  out  3  instr[14:12].
out_funct7b5  out  1  instr[30].
out_reg_w  out  1  register write.
out_mem_w  out  1  memory write.
out_alu_src  out  1  1 = immediate operand B.
out_alu_a_pc  out  1  1 = PC as operand A (AUIPC, JAL).
out_result_src  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm.
out_imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
out_alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded.
out_branch  out  1  conditional branch.
out_jump  out  1  JAL or JALR.
out_jalr  out  1  target = rs1+imm.
out_illegal  out  1  unsupported opcode (see optional feature).

Behaviour:
- Reset (async, rst_n low):
  - occupancy = 0, out_valid = 0, in_ready = 1.
  - All out_* data and control outputs = 0.
  - Reset mid-transfer discards every entry.
- Decode is combinational on in_instr and captured on accept (in_valid & in_ready). Latency = 1 cycle from accept to out_valid.
- Decode table (reg_w, imm_src, alu_src, alu_a_pc, mem_w, result_src, branch, jump, jalr, alu_op):
  - LW 0000011: 1, I, 1, 0, 0, 01, 0, 0, 0, 00.
  - SW 0100011: 0, S, 1, 0, 1, 00, 0, 0, 0, 00.
  - R 0110011: 1, I, 0, 0, 0, 00, 0, 0, 0, 10.
  - BR 1100011: 0, B, 0, 0, 0, 00, 1, 0, 0, 01.
  - I-ALU 0010011: 1, I, 1, 0, 0, 00, 0, 0, 0, 10.
  - JAL 1101111: 1, J, 1, 1, 0, 10, 0, 1, 0, 00.
  - JALR 1100111: 1, I, 1, 0, 0, 10, 0, 1, 1, 00.
  - LUI 0110111: 1, U, 1, 0, 0, 11, 0, 0, 0, 00.
  - AUIPC 0010111: 1, U, 1, 1, 0, 00, 0, 0, 0, 00.
  - Any other opcode: all controls 0.
- Immediates:
  - I = instr[31:20], S = {[31:25],[11:7]}, B = {[31],[7],[30:25],[11:8],0}, J = {[31],[19:12],[20],[30:21],0}; all sign-extended from instr[31].
  - U = {[31:12], 12'b0}, sign-extended to XLEN.
- Skid buffer (SKID_DEPTH=2), states EMPTY/ONE/TWO:
  - in_ready = (state != TWO), registered.
  - EMPTY + accept -> ONE.
  - ONE + accept without output pop -> TWO.
  - ONE + output pop (out_valid & out_ready) without accept -> EMPTY.
  - ONE + simultaneous accept and pop -> ONE, with the new entry presented next cycle.
  - TWO + pop -> ONE, with the second entry promoted.
  - TWO + accept is impossible (in_ready = 0).
  - Output holds entry 0. Order is strictly FIFO.
  - While out_valid & !out_ready, every out_* field is held stable.
- flush:
  - State -> EMPTY next cycle and out_valid -> 0.
  - An accept in the same cycle as flush is discarded.
  - in_ready is 1 the cycle after flush.
- out_valid never asserts without a prior accept. No bubble is inserted when out_ready is held at 1 (throughput 1 instr/cycle).

Optional Feature:
ILLEGAL_INSTR_EN
- Defined:
  - Any opcode outside the table, or R-type with funct7 not in {0000000, 0100000}, sets out_illegal = 1.
  - reg_w, mem_w, branch and jump are forced 0 for that entry.
  - out_valid still asserts so EX can trap.
- Undefined: out_illegal tied 0; unknown opcodes decode to all-zero controls.

Test Plan:
- Reset mid-stream with 2 entries buffered, rst_n low 1 cycle -> out_valid = 0, in_ready = 1, all outputs 0 immediately (async).
- Accept 0x00500093 (addi x1, x0, 5), out_ready = 1 -> next cycle out_valid = 1, reg_w = 1, alu_src = 1, alu_op = 10, out_imm = 5, out_rd = 1.
- Accept 0xFE000EE3 (beq x0, x0, -4) -> branch = 1, imm_src = 010, alu_op = 01, out_imm = 0xFFFFFFFC.
- Three back-to-back instrs with out_ready = 0:
  - after two accepts in_ready = 0; third held.
  - release out_ready -> outputs in original order, none lost or duplicated.
- Two buffered entries plus flush asserted with in_valid = 1 -> next cycle out_valid = 0, state EMPTY; flushed-cycle instr never appears.
- With ILLEGAL_INSTR_EN defined, accept 0x0000007F -> out_illegal = 1, reg_w = 0, mem_w = 0, out_valid = 1.
- With ILLEGAL_INSTR_EN undefined, accept 0x0000007F -> out_illegal = 0, all controls 0.
